step_dir_gen: RTL and testbench
===============================

Name: step_dir_gen

Overview:
Step/direction pulse generator: the transmit end of the step/dir interface that the microstepper consumes on its step and dir pins.
- Accepts move commands (direction, step count, step period) over a valid/ready handshake.
- Emits step pulses of fixed width at the commanded rate.
- Enforces dir setup and hold timing around every step edge.
- Used as a host-side motion source and as a bench driver replacing hand-written step/dir stimulus.

Parameters:
COUNT_W, 16, width of step count and steps_taken
PERIOD_W, 16, width of step period in clk cycles
STEP_HIGH, 4, step high time in cycles (>=1)
DIR_SETUP, 2, cycles dir is stable before a step rising edge after a dir change (>=1)
DIR_HOLD, 2, minimum cycles dir is stable after a step falling edge (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  generator can accept a command
cmd_dir  in  1  requested direction
cmd_steps  in  COUNT_W  number of steps to emit
cmd_period  in  PERIOD_W  rising-to-rising step spacing in cycles
abort  in  1  request early termination
step  out  1  step pulse, registered
dir  out  1  direction, registered
busy  out  1  move in progress
done  out  1  one-cycle completion strobe
steps_taken  out  COUNT_W  steps emitted in current/last move

Behaviour:
- Reset (asynchronous, active-high) forces: state IDLE, step=0, dir=0, busy=0, done=0, steps_taken=0, cmd_ready=1. Reset mid-pulse drops step immediately.
- States: IDLE, SETUP, HIGH, LOW.
- cmd_ready = (state==IDLE); busy = !cmd_ready.
- Effective period: eff = max(cmd_period, STEP_HIGH+DIR_HOLD). eff is latched at accept.
- Accept happens when cmd_valid && cmd_ready at a rising edge (cycle N). At accept: latch steps/eff, clear steps_taken.
- Accept with cmd_steps==0: stay IDLE, dir unchanged, done=1 in cycle N+1.
- Accept with cmd_dir==dir: go to HIGH. step=1 from cycle N+1.
- Accept with cmd_dir!=dir: dir<=cmd_dir at N+1, go to SETUP for DIR_SETUP cycles (N+1..N+DIR_SETUP), then HIGH. step rises at N+1+DIR_SETUP.
- HIGH: step=1 for STEP_HIGH cycles. steps_taken increments in the first HIGH cycle, i.e. coincident with step rising.
- LOW: step=0 for eff-STEP_HIGH cycles. At the end of LOW:
  - if steps_taken==latched steps, or abort is pending: go to IDLE, done=1 for exactly one cycle (the first IDLE cycle, cmd_ready=1 simultaneously);
  - else go to HIGH.
- Step rising-to-rising spacing is exactly eff cycles.
- Back-to-back: a command presented in the done cycle is accepted that cycle; its first step (same dir) rises the next cycle. DIR_HOLD is guaranteed by eff.
- abort is sampled in SETUP/HIGH/LOW and sets abort_pending (cleared on entering IDLE).
  - A HIGH pulse in progress is never truncated; its LOW phase completes in full.
  - abort during SETUP goes to IDLE at end of SETUP with done=1, steps_taken=0, dir keeps its new value.
  - abort in IDLE is ignored.
- dir changes only at accept; never during HIGH/LOW.
- steps_taken holds its final value after done until the next accept.
- Counters: phase counter is PERIOD_W bits. steps_taken wraps never: max cmd_steps = 2^COUNT_W-1.

Test Plan:
- Defaults, after reset, accept {dir=0, steps=3, period=10} at N → step high N+1..N+4, N+11..N+14, N+21..N+24; done=1 at N+31 only; steps_taken=3; dir stays 0.
- Accept {dir=1, steps=1, period=10} from dir=0 at N → dir=1 from N+1, step high N+3..N+6, done at N+13.
- Accept {dir=0, steps=4, period=2} → eff=6; step rising edges 6 cycles apart, each high 4 cycles; done 24 cycles after first rising edge.
- Accept {steps=0} at N → done at N+1; step never asserts; busy never asserts; dir unchanged.
- Accept {steps=5, period=10}; pulse abort during the 2nd HIGH → 2nd pulse full width; done 10 cycles after its rising edge; steps_taken=2; then abort in IDLE → no effect.
- Two cases:
  - Assert reset during HIGH → step=0 and dir=0 same cycle; cmd_ready=1 after release.
  - Separately, hold cmd_valid with a second command through the done cycle → accepted in the done cycle; next step rises exactly one cycle later.

Source files
------------

// File: rtl/step_dir_gen.sv
// Step/direction pulse generator.
// Accepts move commands over valid/ready. Emits fixed-width step pulses at the commanded
// spacing, and keeps dir stable around every step edge.
module step_dir_gen #(
    parameter int unsigned COUNT_W   = 16,
    parameter int unsigned PERIOD_W  = 16,
    parameter int unsigned STEP_HIGH = 4,
    parameter int unsigned DIR_SETUP = 2,
    parameter int unsigned DIR_HOLD  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [COUNT_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    output logic                step,
    output logic                dir,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  steps_taken
);

    typedef enum logic [1:0] {StIdle, StSetup, StHigh, StLow} state_e;

    // The shortest legal period leaves DIR_HOLD low cycles after each pulse, so a
    // back-to-back command with a new dir still respects hold time.
    localparam logic [PERIOD_W-1:0] MinEff   = PERIOD_W'(STEP_HIGH + DIR_HOLD);
    localparam logic [PERIOD_W-1:0] HighLen  = PERIOD_W'(STEP_HIGH);
    localparam logic [PERIOD_W-1:0] HighCnt  = PERIOD_W'(STEP_HIGH - 1);
    localparam logic [PERIOD_W-1:0] SetupCnt = PERIOD_W'(DIR_SETUP - 1);

    state_e               state_q, state_d;
    logic [PERIOD_W-1:0]  cnt_q, cnt_d;
    logic [PERIOD_W-1:0]  eff_q, eff_d;
    logic [COUNT_W-1:0]   steps_tgt_q, steps_tgt_d;
    logic [COUNT_W-1:0]   steps_taken_q, steps_taken_d;
    logic                 abort_q, abort_d;
    logic                 step_q, step_d;
    logic                 dir_q, dir_d;
    logic                 done_q, done_d;

    logic [PERIOD_W-1:0]  eff_in;
    logic                 abort_now;

    // Clamp the requested period so the low phase always covers DIR_HOLD.
    always_comb begin
        eff_in = (cmd_period > MinEff) ? cmd_period : MinEff;
    end

    // Next-state logic for the move sequencer and its registered outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        eff_d         = eff_q;
        steps_tgt_d   = steps_tgt_q;
        steps_taken_d = steps_taken_q;
        abort_d       = abort_q;
        step_d        = step_q;
        dir_d         = dir_q;
        done_d        = 1'b0;
        // An abort in the final cycle of a phase still takes effect at that boundary.
        abort_now     = abort_q | abort;

        unique case (state_q)
            StIdle: begin
                abort_d = 1'b0;
                if (cmd_valid) begin
                    steps_tgt_d   = cmd_steps;
                    eff_d         = eff_in;
                    steps_taken_d = '0;
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else if (cmd_dir == dir_q) begin
                        state_d       = StHigh;
                        step_d        = 1'b1;
                        steps_taken_d = COUNT_W'(1);
                        cnt_d         = HighCnt;
                    end else begin
                        state_d = StSetup;
                        dir_d   = cmd_dir;
                        cnt_d   = SetupCnt;
                    end
                end
            end
            StSetup: begin
                abort_d = abort_now;
                if (cnt_q == '0) begin
                    if (abort_now) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        abort_d = 1'b0;
                    end else begin
                        state_d       = StHigh;
                        step_d        = 1'b1;
                        steps_taken_d = steps_taken_q + COUNT_W'(1);
                        cnt_d         = HighCnt;
                    end
                end else begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end
            end
            StHigh: begin
                // A pulse in flight is never truncated; abort only gets recorded.
                abort_d = abort_now;
                if (cnt_q == '0) begin
                    state_d = StLow;
                    step_d  = 1'b0;
                    cnt_d   = eff_q - HighLen - PERIOD_W'(1);
                end else begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end
            end
            StLow: begin
                abort_d = abort_now;
                if (cnt_q == '0) begin
                    if ((steps_taken_q == steps_tgt_q) || abort_now) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        abort_d = 1'b0;
                    end else begin
                        state_d       = StHigh;
                        step_d        = 1'b1;
                        steps_taken_d = steps_taken_q + COUNT_W'(1);
                        cnt_d         = HighCnt;
                    end
                end else begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                step_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops step and dir immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            eff_q         <= MinEff;
            steps_tgt_q   <= '0;
            steps_taken_q <= '0;
            abort_q       <= 1'b0;
            step_q        <= 1'b0;
            dir_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            eff_q         <= eff_d;
            steps_tgt_q   <= steps_tgt_d;
            steps_taken_q <= steps_taken_d;
            abort_q       <= abort_d;
            step_q        <= step_d;
            dir_q         <= dir_d;
            done_q        <= done_d;
        end
    end

    // Handshake and status outputs.
    always_comb begin
        cmd_ready   = (state_q == StIdle);
        busy        = (state_q != StIdle);
        step        = step_q;
        dir         = dir_q;
        done        = done_q;
        steps_taken = steps_taken_q;
    end

endmodule

// File: tb/tb_step_dir_gen.sv
// Self-checking bench for step_dir_gen: directed scenarios plus random moves, all checked
// cycle by cycle against a timeline model built from the move's rise times.
module tb_step_dir_gen;

    localparam int CW = 16;
    localparam int PW = 16;
    localparam int SH = 4;
    localparam int DS = 2;
    localparam int DH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_dir;
    logic [CW-1:0] cmd_steps;
    logic [PW-1:0] cmd_period;
    logic          abort;
    logic          step;
    logic          dir;
    logic          busy;
    logic          done;
    logic [CW-1:0] steps_taken;

    int   total = 0;
    int   bad   = 0;
    logic cur_dir;

    step_dir_gen #(
        .COUNT_W  (CW),
        .PERIOD_W (PW),
        .STEP_HIGH(SH),
        .DIR_SETUP(DS),
        .DIR_HOLD (DH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .steps_taken(steps_taken)
    );

    always #5 clk = ~clk;

    // Offer a command and return right after the edge that accepts it.
    task automatic issue(input logic d, input int s, input int p);
        int waited = 0;
        @(negedge clk);
        cmd_dir    = d;
        cmd_steps  = CW'(s);
        cmd_period = PW'(p);
        cmd_valid  = 1'b1;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL issue_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk);
    endtask

    // Check a move cycle by cycle from the cycle after accept. Model: first rise r0 cycles
    // after accept, rises every eff cycles, done one period after the last rise.
    task automatic observe(input logic nd_dir, input int steps, input int period,
                           input int abort_at, input bit chain,
                           input logic c_dir, input int c_steps, input int c_period);
        int eff, r0, n_eff, d, last, e_st;
        logic e_step, e_dir, e_busy, e_done;
        eff   = (period > SH + DH) ? period : SH + DH;
        r0    = (nd_dir != cur_dir) ? 1 + DS : 1;
        n_eff = steps;
        if (steps > 0 && abort_at > 0) begin
            if (abort_at < r0) n_eff = 0;
            else if ((abort_at - r0) / eff + 1 < steps) n_eff = (abort_at - r0) / eff + 1;
        end
        d     = (steps == 0) ? 1 : r0 + n_eff * eff;
        last  = chain ? d : d + 2;
        e_dir = (steps == 0) ? cur_dir : nd_dir;
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            if (t == 1) begin
                if (chain) begin
                    cmd_dir    = c_dir;
                    cmd_steps  = CW'(c_steps);
                    cmd_period = PW'(c_period);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            abort  = (t == abort_at);
            e_step = (n_eff > 0) && (t >= r0) && (t < d) && (((t - r0) % eff) < SH);
            e_busy = (t < d);
            e_done = (t == d);
            if (steps == 0 || n_eff == 0 || t < r0) e_st = 0;
            else e_st = ((t - r0) / eff + 1 < n_eff) ? (t - r0) / eff + 1 : n_eff;
            total += 5;
            if (step !== e_step) begin
                bad++;
                $display("FAIL step t=%0d: got %b want %b (steps=%0d per=%0d)", t, step, e_step,
                         steps, period);
            end
            if (dir !== e_dir) begin
                bad++;
                $display("FAIL dir t=%0d: got %b want %b", t, dir, e_dir);
            end
            if (busy !== e_busy || cmd_ready !== !e_busy) begin
                bad++;
                $display("FAIL busy t=%0d: busy=%b ready=%b want busy %b", t, busy, cmd_ready,
                         e_busy);
            end
            if (done !== e_done) begin
                bad++;
                $display("FAIL done t=%0d: got %b want %b", t, done, e_done);
            end
            if (steps_taken !== CW'(e_st)) begin
                bad++;
                $display("FAIL steps_taken t=%0d: got %0d want %0d", t, steps_taken, e_st);
            end
        end
        abort   = 1'b0;
        cur_dir = e_dir;
        if (chain) @(posedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (step !== 1'b0 || dir !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            steps_taken !== '0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: step=%b dir=%b busy=%b done=%b st=%0d ready=%b want 0 0 0 0 0 1",
                     step, dir, busy, done, steps_taken, cmd_ready);
        end
        reset = 1'b0;
        cur_dir = 1'b0;
    endtask

    task automatic test_basic;
        issue(1'b0, 3, 10);
        observe(1'b0, 3, 10, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_dir_change;
        issue(1'b1, 1, 10);
        observe(1'b1, 1, 10, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_min_period;
        issue(1'b1, 4, 2);
        observe(1'b1, 4, 2, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_zero;
        issue(!cur_dir, 0, 10);
        observe(!cur_dir, 0, 10, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_abort;
        // Second pulse rises 11 cycles after accept; abort lands in its high phase.
        issue(cur_dir, 5, 10);
        observe(cur_dir, 5, 10, 12, 1'b0, 1'b0, 0, 0);
        // Abort while idle must leave nothing pending.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || step !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL idle_abort: busy=%b step=%b done=%b want 0 0 0", busy, step, done);
            end
        end
        issue(cur_dir, 2, 7);
        observe(cur_dir, 2, 7, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_abort_setup;
        issue(!cur_dir, 3, 10);
        observe(!cur_dir, 3, 10, 1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid;
        int waited = 0;
        issue(1'b1, 3, 10);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        while (step !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (step !== 1'b1 || dir !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pre: step=%b dir=%b want 1 1", step, dir);
        end
        reset = 1'b1;
        #1;
        total++;
        if (step !== 1'b0 || dir !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_async: step=%b dir=%b busy=%b want 0 0 0", step, dir, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || steps_taken !== '0 || step !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_post: ready=%b st=%0d step=%b want 1 0 0", cmd_ready,
                     steps_taken, step);
        end
        cur_dir = 1'b0;
    endtask

    task automatic test_back_to_back;
        issue(1'b0, 2, 8);
        observe(1'b0, 2, 8, 0, 1'b1, 1'b0, 3, 7);
        observe(1'b0, 3, 7, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_random;
        localparam int N = 25;
        logic d, nd;
        int s, p, ns, np, ab, eff, r0, full;
        bit ch;
        d = 1'($urandom_range(0, 1));
        s = $urandom_range(0, 5);
        p = $urandom_range(0, 14);
        issue(d, s, p);
        for (int i = 0; i < N; i++) begin
            eff  = (p > SH + DH) ? p : SH + DH;
            r0   = (d != cur_dir) ? 1 + DS : 1;
            full = (s == 0) ? 1 : r0 + s * eff;
            ab   = (s > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, full - 1) : 0;
            ch   = (i < N - 1) && ($urandom_range(0, 1) == 1);
            nd   = 1'($urandom_range(0, 1));
            ns   = $urandom_range(0, 5);
            np   = $urandom_range(0, 14);
            observe(d, s, p, ab, ch, nd, ns, np);
            if (i < N - 1) begin
                if (!ch) issue(nd, ns, np);
                d = nd;
                s = ns;
                p = np;
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        abort      = 1'b0;
        cur_dir    = 1'b0;
        test_reset;
        test_basic;
        test_dir_change;
        test_min_period;
        test_zero;
        test_abort;
        test_abort_setup;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
